// File: rtl/connect4_pkg.sv
// Shared definitions for the Connect-4 Pop-Out controller: board geometry,
// cell encodings, controller states and the flat board index helper.
package connect4_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int BW   = 2 * ROWS * COLS;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FALL  = 3'd1,
        S_POP   = 3'd2,
        S_CHECK = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // Flat cell index; cell(r,c) occupies board[2*idx(r,c) +: 2].
    function automatic int idx(input int r, input int c);
        return r * COLS + c;
    endfunction

endpackage

// File: rtl/connect4_move_ctrl_if.sv
// Signal bundle between the game controller and its surroundings
// (button/keypad front end, animation timer, win checker, renderer).
//
// Handshake: there is no backpressure anywhere. tick, btn_*, key_valid are
// one-clk strobes sampled on the rising edge they are high; the controller
// drops any strobe it cannot act on that cycle. win_in is a level that the
// controller samples in the second CHECK cycle. All slave outputs are levels
// except illegal, which is a one-clk pulse.
interface connect4_move_ctrl_if;
    import connect4_pkg::*;

    logic            tick;
    logic            btn_left;
    logic            btn_right;
    logic            btn_drop;
    logic            btn_pop;
    logic            key_valid;
    logic [3:0]      key_code;
    logic [1:0]      win_in;

    logic [BW-1:0]   board;
    logic [2:0]      cursor;
    logic            turn;
    logic            fall_valid;
    logic [2:0]      fall_row;
    logic            busy;
    logic            illegal;
    logic            game_over;
    logic [1:0]      winner;
    state_t          dbg_state;

    modport master (
        output tick, btn_left, btn_right, btn_drop, btn_pop,
               key_valid, key_code, win_in,
        input  board, cursor, turn, fall_valid, fall_row, busy,
               illegal, game_over, winner, dbg_state
    );

    modport slave (
        input  tick, btn_left, btn_right, btn_drop, btn_pop,
               key_valid, key_code, win_in,
        output board, cursor, turn, fall_valid, fall_row, busy,
               illegal, game_over, winner, dbg_state
    );

endinterface

// File: rtl/connect4_win_check.sv
// Combinational four-in-a-row detector. Sits next to the controller and
// feeds its win_in; bit 0 = P1 has four, bit 1 = P2 has four.
module connect4_win_check
    import connect4_pkg::*;
(
    input  logic [BW-1:0] board_i,
    output logic [1:0]    win_o
);

    function automatic logic [1:0] cell_at(input logic [BW-1:0] b, input int r, input int c);
        return b[2*idx(r, c) +: 2];
    endfunction

    // Returns the owner code of a run of four from (r,c) along (dr,dc),
    // or 00; the owner code doubles as the matching win bit.
    function automatic logic [1:0] four(input logic [BW-1:0] b, input int r, input int c,
                                        input int dr, input int dc);
        logic [1:0] a;
        a = cell_at(b, r, c);
        if (a != EMPTY &&
            cell_at(b, r + dr,     c + dc)     == a &&
            cell_at(b, r + 2 * dr, c + 2 * dc) == a &&
            cell_at(b, r + 3 * dr, c + 3 * dc) == a)
            return a;
        return 2'b00;
    endfunction

    // OR together every horizontal, vertical and diagonal window.
    always_comb begin
        win_o = 2'b00;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c <= COLS - 4; c++)
                win_o = win_o | four(board_i, r, c, 0, 1);
        for (int r = 0; r <= ROWS - 4; r++)
            for (int c = 0; c < COLS; c++)
                win_o = win_o | four(board_i, r, c, 1, 0);
        for (int r = 0; r <= ROWS - 4; r++)
            for (int c = 0; c <= COLS - 4; c++)
                win_o = win_o | four(board_i, r, c, 1, 1);
        for (int r = 0; r <= ROWS - 4; r++)
            for (int c = 3; c < COLS; c++)
                win_o = win_o | four(board_i, r, c, 1, -1);
    end

endmodule

// File: rtl/connect4_move_ctrl.sv
// Connect-4 Pop-Out game sequencer: owns board, cursor and turn, animates
// falling pieces and pop-out shifts on the tick strobe, then samples the
// external win checker over two CHECK cycles.
module connect4_move_ctrl
    import connect4_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    connect4_move_ctrl_if.slave  bus
);

    state_t          state_q;
    logic [BW-1:0]   board_q;
    logic [2:0]      cursor_q;
    logic            turn_q;
    logic            fall_valid_q;
    logic [2:0]      fall_row_q;
    logic            busy_q;
    logic            illegal_q;
    logic            game_over_q;
    logic [1:0]      winner_q;
    logic            check_cnt_q;

    logic [1:0]      col_v [ROWS];
    logic            landed;
    logic            new_game;
    logic            key_col;
    cell_t           own;

    assign new_game = bus.key_valid && (bus.key_code == 4'd0);
    assign key_col  = bus.key_valid && (bus.key_code != 4'd0) && (bus.key_code <= 4'd7);
    assign own      = turn_q ? P2 : P1;

    // Cursor column, bottom row first.
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            col_v[r] = board_q[2*idx(r, int'(cursor_q)) +: 2];
    end

    // The falling piece stops on the floor or on an occupied cell below it.
    always_comb begin
        landed = 1'b1;
        for (int r = 1; r < ROWS; r++)
            if (int'(fall_row_q) == r)
                landed = (col_v[r-1] != EMPTY);
    end

    // Game FSM with all outputs registered; new game behaves like reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            board_q      <= '0;
            cursor_q     <= 3'd3;
            turn_q       <= 1'b0;
            fall_valid_q <= 1'b0;
            fall_row_q   <= 3'd0;
            busy_q       <= 1'b0;
            illegal_q    <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
            check_cnt_q  <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            if (new_game) begin
                state_q      <= S_IDLE;
                board_q      <= '0;
                cursor_q     <= 3'd3;
                turn_q       <= 1'b0;
                fall_valid_q <= 1'b0;
                fall_row_q   <= 3'd0;
                busy_q       <= 1'b0;
                game_over_q  <= 1'b0;
                winner_q     <= 2'b00;
                check_cnt_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.btn_drop) begin
                            if (col_v[ROWS-1] != EMPTY) begin
                                illegal_q <= 1'b1;
                            end else begin
                                fall_row_q   <= 3'(ROWS - 1);
                                fall_valid_q <= 1'b1;
                                busy_q       <= 1'b1;
                                state_q      <= S_FALL;
                            end
                        end else if (bus.btn_pop) begin
                            if (col_v[0] == own) begin
                                busy_q  <= 1'b1;
                                state_q <= S_POP;
                            end else begin
                                illegal_q <= 1'b1;
                            end
                        end else if (bus.btn_left) begin
                            if (cursor_q != 3'd0)
                                cursor_q <= cursor_q - 3'd1;
                        end else if (bus.btn_right) begin
                            if (cursor_q != 3'(COLS - 1))
                                cursor_q <= cursor_q + 3'd1;
                        end else if (key_col) begin
                            cursor_q <= bus.key_code[2:0] - 3'd1;
                        end
                    end
                    S_FALL: begin
                        if (bus.tick) begin
                            if (landed) begin
                                board_q[2*idx(int'(fall_row_q), int'(cursor_q)) +: 2] <= own;
                                fall_valid_q <= 1'b0;
                                check_cnt_q  <= 1'b0;
                                state_q      <= S_CHECK;
                            end else begin
                                fall_row_q <= fall_row_q - 3'd1;
                            end
                        end
                    end
                    S_POP: begin
                        if (bus.tick) begin
                            for (int r = 0; r < ROWS - 1; r++)
                                board_q[2*idx(r, int'(cursor_q)) +: 2] <= col_v[r+1];
                            board_q[2*idx(ROWS - 1, int'(cursor_q)) +: 2] <= EMPTY;
                            check_cnt_q <= 1'b0;
                            state_q     <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (!check_cnt_q) begin
                            check_cnt_q <= 1'b1;
                        end else begin
                            check_cnt_q <= 1'b0;
                            busy_q      <= 1'b0;
                            if (bus.win_in == 2'b00) begin
                                turn_q  <= ~turn_q;
                                state_q <= S_IDLE;
                            end else begin
                                winner_q    <= bus.win_in;
                                game_over_q <= 1'b1;
                                state_q     <= S_OVER;
                            end
                        end
                    end
                    S_OVER: begin
                        state_q <= S_OVER;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.board      = board_q;
    assign bus.cursor     = cursor_q;
    assign bus.turn       = turn_q;
    assign bus.fall_valid = fall_valid_q;
    assign bus.fall_row   = fall_row_q;
    assign bus.busy       = busy_q;
    assign bus.illegal    = illegal_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: doc/connect4_move_ctrl.md
Name: connect4_move_ctrl

Overview:
- Game-sequencing controller for the Connect-4 Pop-Out design.
- Inputs: debounced button pulses (left/right/drop/pop), keypad decode nibble, an animation tick strobe.
- Owns the 6x7 board register, the cursor and the turn.
- Sequences the falling-piece animation and pop-out shifts, then samples an external win checker.
- Board and status outputs feed the VGA renderer and 7-segment display.

Parameters:
- ROWS, 6, board rows (row 0 = bottom)
- COLS, 7, board columns (col 0 = left)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-clk strobe at animation rate (10 Hz, synchronised to clk)
- btn_left  in  1  one-clk pulse, cursor left
- btn_right  in  1  one-clk pulse, cursor right
- btn_drop  in  1  one-clk pulse, drop piece in cursor column
- btn_pop  in  1  one-clk pulse, pop bottom piece of cursor column
- key_valid  in  1  one-clk pulse, key_code valid
- key_code  in  4  keypad value: 1..7 select column 0..6; 0 = new game; others ignored
- win_in  in  2  from win checker on current board: [0] P1 has four, [1] P2 has four
- board  out  84  cell(r,c) = board[2*(r*7+c)+:2]; 00 empty, 01 P1, 10 P2
- cursor  out  3  selected column 0..6
- turn  out  1  0 = P1 to move, 1 = P2
- fall_valid  out  1  animated piece present
- fall_row  out  3  row of animated piece (column = cursor)
- busy  out  1  high in FALL/POP/CHECK
- illegal  out  1  one-clk pulse on a rejected move
- game_over  out  1  high in OVER
- winner  out  2  01 P1, 10 P2, 11 draw, 00 none

Behaviour:
- Reset (async, rst_n low): board=0, cursor=3, turn=0, fall_valid=0, fall_row=0, illegal=0, winner=00, state=IDLE.
- States: IDLE, FALL, POP, CHECK, OVER. All outputs registered.
- Per-cycle input priority: new game (key_valid & key_code==0) > drop > pop > left/right > key column select. At most one action per cycle; lower-priority inputs that cycle are dropped.
- New game: accepted in any state, same effect as reset on the next edge.
- IDLE, cursor moves:
  - left/right move the cursor by 1, saturating at 0 and 6.
  - Key 1..7 sets cursor = key_code-1.
- IDLE, drop:
  - Column full (cell(5,cursor)!=0): illegal=1 for one cycle, stay IDLE.
  - Otherwise fall_row=5, fall_valid=1, go to FALL.
- FALL, on each tick:
  - If fall_row==0 or cell(fall_row-1,cursor)!=0: write turn+1 into cell(fall_row,cursor), clear fall_valid, go to CHECK.
  - Else decrement fall_row.
  - Landing row r therefore takes 6-r ticks.
- IDLE, pop:
  - Legal only if cell(0,cursor)==turn+1; otherwise illegal pulse, stay IDLE.
  - Legal: go to POP.
- POP, on next tick: column shifts down (cell(r)=cell(r+1) for r=0..4, cell(5)=00), go to CHECK.
- Cursor, left/right and keys are ignored while busy or OVER (except new game).
- CHECK: two cycles.
  - Cycle 1 lets the checker settle on the updated board.
  - Cycle 2 samples win_in:
    - 00: toggle turn, go to IDLE.
    - 01/10: winner=win_in, go to OVER.
    - 11 (possible after a pop): winner=11 draw, go to OVER.
- OVER: board frozen, game_over=1; only new game leaves.
- A full board is not a draw; play continues via pops. The case where a player has no legal move is not detected.
- Tick arriving on the same cycle as acceptance of a drop/pop has no effect; counting starts on the next tick.

Decomposition:
- Package connect4_pkg:
  - ROWS and COLS.
  - Cell encodings EMPTY/P1/P2.
  - State enum.
  - Cell-index function idx(r,c)=r*COLS+c.
- Natural sub-module: connect4_win_check, the combinational 4-in-a-row detector that drives win_in. It is instantiated alongside this block, not inside it.

Test Plan:
- Reset, P1 drops in col 3 with 6 ticks -> fall_row 5..0, cell(0,3)=01, turn=1, busy low after 2 CHECK cycles.
- Fill col 0 with 6 drops, then 7th drop -> illegal one pulse, board unchanged, turn unchanged.
- P2 pops when cell(0,c)=P1 -> illegal; P1 pops own piece under stack 01,10,01 -> after tick column reads 10,01,00; turn toggles.
- Force win_in=01 at sample cycle -> winner=01, game_over=1; then drop/left ignored; key 0 -> board=0, cursor=3, winner=00.
- btn_drop and btn_left same cycle in IDLE -> drop executes, cursor unchanged; btn_left at cursor 0 -> stays 0; key 7 -> cursor 6.
- rst_n low mid-FALL -> immediate reset values, fall_valid=0, no cell written.
